// File: rtl/prog_mem_loader.sv
// Writable instruction memory: clears to NOP, accepts a program over a
// valid/ready stream from address 0, then serves registered fetches.
module prog_mem_loader #(
    parameter int                DATA_W   = 9,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b1}}
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Load_Valid,
    input  logic [DATA_W-1:0] i_Load_Data,
    input  logic              i_Load_Last,
    output logic              o_Load_Ready,
    input  logic              i_Reload,
    input  logic [ADDR_W-1:0] i_Address,
    input  logic              i_Fetch_En,
    output logic [DATA_W-1:0] o_Instruction,
    output logic              o_Instr_Valid,
    output logic              o_Run,
    output logic [ADDR_W:0]   o_Prog_Len,
    output logic              o_Error
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_ERROR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, wr_ptr;
    logic [ADDR_W:0]     prog_len;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we, xfer, load_ready, do_reload;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   instr;
    logic                instr_valid;

    // Reload is deliberately ignored while the clear sweep is running.
    assign do_reload = i_Reload && (state != S_CLEAR);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) state <= S_CLEAR;
        else          state <= state_nxt;
    end

    // One shared write port: the clear sweep and the load stream never overlap.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        xfer       = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr;
        mem_wdata  = NOP_WORD;
        case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr == LAST_ADDR) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (i_Reload) begin
                    state_nxt = S_CLEAR;
                end else begin
                    load_ready = 1'b1;
                    if (i_Load_Valid) begin
                        xfer      = 1'b1;
                        mem_we    = 1'b1;
                        mem_waddr = wr_ptr;
                        mem_wdata = i_Load_Data;
                        if (i_Load_Last)             state_nxt = S_RUN;
                        else if (wr_ptr == LAST_ADDR) state_nxt = S_ERROR;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                if (i_Reload) state_nxt = S_CLEAR;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || do_reload) begin
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            prog_len <= '0;
        end else begin
            if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
            if (xfer) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                prog_len <= prog_len + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Fetch register holds NOP outside run mode so the core never sees stale code.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
        end else if (state == S_RUN && !i_Reload) begin
            if (i_Fetch_En) begin
                instr       <= mem[i_Address];
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end else begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
        end
    end

    assign o_Load_Ready  = load_ready;
    assign o_Instruction = instr;
    assign o_Instr_Valid = instr_valid;
    assign o_Run         = (state == S_RUN);
    assign o_Error       = (state == S_ERROR);
    assign o_Prog_Len    = prog_len;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader at DATA_W=9, ADDR_W=4 (16 words).
module tb_prog_mem_loader;
    localparam int DW = 9;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          reload = 1'b0;
    logic [AW-1:0] address = '0;
    logic          fetch_en = 1'b0;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          run;
    logic [AW:0]   prog_len;
    logic          error;

    int tests = 0;
    int fails = 0;
    int n;

    prog_mem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Load_Valid(load_valid), .i_Load_Data(load_data), .i_Load_Last(load_last),
        .o_Load_Ready(load_ready), .i_Reload(reload),
        .i_Address(address), .i_Fetch_En(fetch_en),
        .o_Instruction(instruction), .o_Instr_Valid(instr_valid),
        .o_Run(run), .o_Prog_Len(prog_len), .o_Error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic l);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        address  = a;
        fetch_en = 1'b1;
        tick();
    endtask

    // Counts cycles until ready rises; bounded so a stuck clear still ends the run.
    task automatic wait_ready(input string tag);
        n = 0;
        while (!load_ready && n < 100) begin
            tick();
            n++;
        end
        chk(tag, n, 16);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    logic [DW-1:0] prog [14] = '{9'h1FF, 9'h00A, 9'h013, 9'h021, 9'h02D, 9'h148, 9'h118,
                                 9'h102, 9'h161, 9'h110, 9'h103, 9'h1AB, 9'h009, 9'h0C8};

    initial begin
        // 1. reset and clear sweep
        tick();
        tick();
        chk("rst_ready", load_ready, 0);
        chk("rst_run", run, 0);
        chk("rst_error", error, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_instr", instruction, 9'h1FF);
        chk("rst_ivalid", instr_valid, 0);
        rst_n = 1'b1;
        wait_ready("clear_cycles_reset");

        // 2. load 14 words back to back, then fetch
        for (int i = 0; i < 14; i++) load_word(prog[i], i == 13);
        chk("load_run", run, 1);
        chk("load_len", prog_len, 14);
        chk("load_ready_run", load_ready, 0);
        fetch(4'd1);
        chk("fetch1", instruction, 9'h00A);
        chk("fetch1_v", instr_valid, 1);
        fetch(4'd13);
        chk("fetch13", instruction, 9'h0C8);
        fetch(4'd15);
        chk("fetch15", instruction, 9'h1FF);
        chk("fetch15_v", instr_valid, 1);
        fetch_en = 1'b0;
        tick();
        chk("nofetch_v", instr_valid, 0);
        chk("nofetch_hold", instruction, 9'h1FF);
        fetch(4'd5);
        chk("fetch5", instruction, 9'h148);

        // 5b. reload in RUN with a simultaneous fetch
        address = 4'd1;
        reload  = 1'b1;
        tick();
        reload  = 1'b0;
        fetch_en = 1'b0;
        chk("rl_run_v", instr_valid, 0);
        chk("rl_run_instr", instruction, 9'h1FF);
        chk("rl_run_run", run, 0);
        chk("rl_run_len", prog_len, 0);
        wait_ready("clear_cycles_rl_run");

        // 3. backpressure gaps
        load_word(9'h011, 1'b0);
        load_data = 9'h0AA; tick();
        load_data = 9'h0BB; tick();
        load_word(9'h022, 1'b0);
        load_word(9'h033, 1'b1);
        chk("gap_len", prog_len, 3);
        chk("gap_run", run, 1);
        fetch(4'd0); chk("gap_m0", instruction, 9'h011);
        fetch(4'd1); chk("gap_m1", instruction, 9'h022);
        fetch(4'd2); chk("gap_m2", instruction, 9'h033);
        fetch(4'd3); chk("gap_m3", instruction, 9'h1FF);
        fetch_en = 1'b0;

        // 4. overflow
        do_reload();
        wait_ready("clear_cycles_ovf");
        for (int i = 0; i < 15; i++) load_word(DW'(9'h040 + i), 1'b0);
        chk("ovf_pre_err", error, 0);
        chk("ovf_pre_ready", load_ready, 1);
        load_word(9'h04F, 1'b0);
        chk("ovf_err", error, 1);
        chk("ovf_len", prog_len, 16);
        chk("ovf_ready", load_ready, 0);
        chk("ovf_run", run, 0);
        fetch(4'd0);
        chk("ovf_fetch_v", instr_valid, 0);
        chk("ovf_fetch_i", instruction, 9'h1FF);
        fetch_en = 1'b0;
        do_reload();
        chk("ovf_rl_err", error, 0);
        chk("ovf_rl_len", prog_len, 0);
        wait_ready("clear_cycles_ovf_rl");

        // 5. reload colliding with a valid word in LOAD
        load_word(9'h101, 1'b0);
        load_word(9'h102, 1'b0);
        chk("rl_ld_len2", prog_len, 2);
        reload     = 1'b1;
        load_valid = 1'b1;
        load_data  = 9'h055;
        #1;
        chk("rl_ld_ready", load_ready, 0);
        tick();
        reload     = 1'b0;
        load_valid = 1'b0;
        chk("rl_ld_len", prog_len, 0);
        chk("rl_ld_ready_clr", load_ready, 0);
        wait_ready("clear_cycles_rl_ld");
        load_word(9'h0AA, 1'b1);
        chk("rl_ld_len1", prog_len, 1);
        fetch(4'd1); chk("rl_ld_m1", instruction, 9'h1FF);
        fetch(4'd0); chk("rl_ld_m0", instruction, 9'h0AA);
        fetch_en = 1'b0;

        // 6. reset mid-load
        do_reload();
        wait_ready("clear_cycles_pre6");
        for (int i = 0; i < 5; i++) load_word(DW'(9'h060 + i), 1'b0);
        chk("mid_len5", prog_len, 5);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", load_ready, 0);
        chk("mid_rst_len", prog_len, 0);
        chk("mid_rst_run", run, 0);
        chk("mid_rst_err", error, 0);
        chk("mid_rst_instr", instruction, 9'h1FF);
        chk("mid_rst_v", instr_valid, 0);
        rst_n = 1'b1;
        wait_ready("clear_cycles_mid");
        load_word(9'h077, 1'b1);
        chk("mid_len1", prog_len, 1);
        fetch(4'd5); chk("mid_m5", instruction, 9'h1FF);
        fetch(4'd0); chk("mid_m0", instruction, 9'h077);
        fetch_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
